// File: rtl/vga_pkg.sv
// vga_pkg: shared types for the display timing path.
// Segment state encodings, timing bundle and delay-line limit.
package vga_pkg;

   localparam int VGA_MAX_H_WIDTH = 12;
   localparam int VGA_MAX_V_WIDTH = 11;
   localparam int VGA_MAX_OUT_LAT = 4;

   typedef enum logic [1:0] {
      H_ACT, H_FP, H_SYNC, H_BP
   } h_state_e;

   typedef enum logic [1:0] {
      V_ACT, V_FP, V_SYNC, V_BP
   } v_state_e;

   typedef enum logic [1:0] {
      SEG_ACT, SEG_FP, SEG_SYNC, SEG_BP
   } seg_state_e;

   typedef struct packed {
      logic [VGA_MAX_H_WIDTH-1:0] hd;
      logic [VGA_MAX_H_WIDTH-1:0] hf;
      logic [VGA_MAX_H_WIDTH-1:0] hr;
      logic [VGA_MAX_H_WIDTH-1:0] hb;
      logic [VGA_MAX_V_WIDTH-1:0] vd;
      logic [VGA_MAX_V_WIDTH-1:0] vf;
      logic [VGA_MAX_V_WIDTH-1:0] vr;
      logic [VGA_MAX_V_WIDTH-1:0] vb;
   } vga_timing_t;

endpackage

// File: rtl/vga_seg_fsm.sv
// vga_seg_fsm: four-segment down-counting state machine.
// Used once per axis; end_o marks the last unit of the back porch.
module vga_seg_fsm
   import vga_pkg::*;
#(
   parameter int W = 12
) (
   input  logic         clk_i,
   input  logic         arstn_i,
   input  logic         load_i,
   input  logic         adv_i,
   input  logic [W-1:0] len_act_i,
   input  logic [W-1:0] len_fp_i,
   input  logic [W-1:0] len_sync_i,
   input  logic [W-1:0] len_bp_i,
   output seg_state_e   state_o,
   output logic [W-1:0] pos_o,
   output logic         end_o
);

   localparam logic [W-1:0] ONE = W'(1);

   seg_state_e   state_q;
   seg_state_e   nxt_state;
   logic [W-1:0] nxt_len;
   logic [W-1:0] cnt_q;
   logic [W-1:0] pos_q;

   // successor segment and its length
   always_comb begin
      nxt_state = SEG_ACT;
      nxt_len   = len_act_i;
      unique case (state_q)
         SEG_ACT: begin
            nxt_state = SEG_FP;
            nxt_len   = len_fp_i;
         end
         SEG_FP: begin
            nxt_state = SEG_SYNC;
            nxt_len   = len_sync_i;
         end
         SEG_SYNC: begin
            nxt_state = SEG_BP;
            nxt_len   = len_bp_i;
         end
         SEG_BP: begin
            nxt_state = SEG_ACT;
            nxt_len   = len_act_i;
         end
      endcase
   end

   // segment state, remaining count and active position
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q <= SEG_ACT;
         cnt_q   <= '0;
         pos_q   <= '0;
      end else if (load_i) begin
         state_q <= SEG_ACT;
         cnt_q   <= len_act_i - ONE;
         pos_q   <= '0;
      end else if (adv_i) begin
         if (cnt_q == '0) begin
            state_q <= nxt_state;
            cnt_q   <= nxt_len - ONE;
            pos_q   <= '0;
         end else begin
            cnt_q <= cnt_q - ONE;
            if (state_q == SEG_ACT) pos_q <= pos_q + ONE;
         end
      end
   end

   assign state_o = state_q;
   assign pos_o   = pos_q;
   assign end_o   = (state_q == SEG_BP) && (cnt_q == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA/DVI timing with shadowed config,
// sync polarity and a pix_en-qualified output delay line.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_W     = 12,
   parameter int   V_W     = 11,
   parameter logic HS_POL  = 1'b0,
   parameter logic VS_POL  = 1'b0,
   parameter int   OUT_LAT = 1
) (
   input  logic           clk_i,
   input  logic           arstn_i,
   input  logic           pix_en_i,
   input  logic [H_W-1:0] hd_i,
   input  logic [H_W-1:0] hf_i,
   input  logic [H_W-1:0] hr_i,
   input  logic [H_W-1:0] hb_i,
   input  logic [V_W-1:0] vd_i,
   input  logic [V_W-1:0] vf_i,
   input  logic [V_W-1:0] vr_i,
   input  logic [V_W-1:0] vb_i,
   input  logic           cfg_we_i,
   output logic           cfg_pending_o,
   output logic           cfg_err_o,
   output logic           hsync_o,
   output logic           vsync_o,
   output logic           de_o,
   output logic [H_W-1:0] hcount_o,
   output logic [V_W-1:0] vcount_o,
   output logic           sol_o,
   output logic           sof_o
);

   typedef struct packed {
      logic           hsync;
      logic           vsync;
      logic           de;
      logic           sol;
      logic           sof;
      logic [H_W-1:0] hcount;
      logic [V_W-1:0] vcount;
   } out_t;

   localparam out_t OUT_RST = {~HS_POL, ~VS_POL, 3'b000,
                               {H_W{1'b0}}, {V_W{1'b0}}};

   vga_timing_t wr, act_q, stg_q, nxt, lens;
   logic        run_q, arm_q, pend_q, err_q;
   logic        ok, bad, load, frame_end;
   logic        h_adv, v_adv, h_end, v_end;
   seg_state_e  h_seg, v_seg;
   h_state_e    h_st;
   v_state_e    v_st;
   logic [H_W-1:0] h_pos;
   logic [V_W-1:0] v_pos;
   out_t        stg0;
   out_t        dly [OUT_LAT];

   // widen the write fields into the timing bundle
   always_comb begin
      wr = '0;
      wr.hd[H_W-1:0] = hd_i;
      wr.hf[H_W-1:0] = hf_i;
      wr.hr[H_W-1:0] = hr_i;
      wr.hb[H_W-1:0] = hb_i;
      wr.vd[V_W-1:0] = vd_i;
      wr.vf[V_W-1:0] = vf_i;
      wr.vr[V_W-1:0] = vr_i;
      wr.vb[V_W-1:0] = vb_i;
   end

   assign bad = cfg_we_i &&
                (hd_i == '0 || hf_i == '0 ||
                 hr_i == '0 || hb_i == '0 ||
                 vd_i == '0 || vf_i == '0 ||
                 vr_i == '0 || vb_i == '0);
   assign ok        = cfg_we_i && !bad;
   assign load      = arm_q && pix_en_i;
   assign h_adv     = run_q && pix_en_i;
   assign v_adv     = h_adv && h_end;
   assign frame_end = v_adv && v_end;

   // a write on the boundary beats the staged copy
   always_comb begin
      nxt = act_q;
      if (ok) nxt = wr;
      else if (pend_q) nxt = stg_q;
   end

   assign lens = (frame_end || load) ? nxt : act_q;

   // active/staged config, start handshake and status flags
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         act_q  <= '0;
         stg_q  <= '0;
         run_q  <= 1'b0;
         arm_q  <= 1'b0;
         pend_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         err_q <= bad;
         if (ok && !run_q) begin
            act_q <= wr;
            arm_q <= 1'b1;
         end else if (ok && frame_end) begin
            act_q  <= wr;
            pend_q <= 1'b0;
         end else if (ok) begin
            stg_q  <= wr;
            pend_q <= 1'b1;
         end else if (frame_end && pend_q) begin
            act_q  <= stg_q;
            pend_q <= 1'b0;
         end
         if (load) begin
            run_q <= 1'b1;
            arm_q <= 1'b0;
         end
      end
   end

   vga_seg_fsm #(.W(H_W)) u_h (
      .clk_i      (clk_i),
      .arstn_i    (arstn_i),
      .load_i     (load),
      .adv_i      (h_adv),
      .len_act_i  (lens.hd[H_W-1:0]),
      .len_fp_i   (lens.hf[H_W-1:0]),
      .len_sync_i (lens.hr[H_W-1:0]),
      .len_bp_i   (lens.hb[H_W-1:0]),
      .state_o    (h_seg),
      .pos_o      (h_pos),
      .end_o      (h_end)
   );

   vga_seg_fsm #(.W(V_W)) u_v (
      .clk_i      (clk_i),
      .arstn_i    (arstn_i),
      .load_i     (load),
      .adv_i      (v_adv),
      .len_act_i  (lens.vd[V_W-1:0]),
      .len_fp_i   (lens.vf[V_W-1:0]),
      .len_sync_i (lens.vr[V_W-1:0]),
      .len_bp_i   (lens.vb[V_W-1:0]),
      .state_o    (v_seg),
      .pos_o      (v_pos),
      .end_o      (v_end)
   );

   assign h_st = h_state_e'(h_seg);
   assign v_st = v_state_e'(v_seg);

   // decode FSM state into pin-level video signals
   always_comb begin
      stg0 = OUT_RST;
      if (run_q) begin
         stg0.de    = (h_st == H_ACT) && (v_st == V_ACT);
         stg0.hsync = (h_st == H_SYNC) ? HS_POL : ~HS_POL;
         stg0.vsync = (v_st == V_SYNC) ? VS_POL : ~VS_POL;
         stg0.hcount = stg0.de ? h_pos : '0;
         stg0.vcount = (v_st == V_ACT) ? v_pos : '0;
         stg0.sol   = stg0.de && (h_pos == '0);
         stg0.sof   = stg0.sol && (v_pos == '0);
      end
   end

   for (genvar i = 0; i < OUT_LAT; i++) begin : g_dly
      if (i == 0) begin : g_head
         // first stage samples the decoded FSM view
         always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) dly[0] <= OUT_RST;
            else if (pix_en_i) dly[0] <= stg0;
         end
      end else begin : g_tail
         // later stages shift only on enabled pixels
         always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) dly[i] <= OUT_RST;
            else if (pix_en_i) dly[i] <= dly[i-1];
         end
      end
   end

   assign hsync_o       = dly[OUT_LAT-1].hsync;
   assign vsync_o       = dly[OUT_LAT-1].vsync;
   assign de_o          = dly[OUT_LAT-1].de;
   assign sol_o         = dly[OUT_LAT-1].sol;
   assign sof_o         = dly[OUT_LAT-1].sof;
   assign hcount_o      = dly[OUT_LAT-1].hcount;
   assign vcount_o      = dly[OUT_LAT-1].vcount;
   assign cfg_pending_o = pend_q;
   assign cfg_err_o     = err_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/DVI timing generator for the display pipeline. It produces hsync, vsync, data-enable, active-area coordinates and line/frame start strobes from runtime-programmable porch and sync lengths. It adds three things over the fixed-order counter design:
- Shadowed configuration, applied only at a frame boundary, for tear-free mode switching.
- Configurable sync polarity.
- A pixel-clock enable and an output delay line that align sync and DE with a pipelined pixel source.

## Interface
- H_W, 12, width of horizontal segment lengths and hcount
- V_W, 11, width of vertical segment lengths and vcount
- HS_POL, 1'b0, active level of hsync_o (0 = active-low, the VESA 640x480 convention)
- VS_POL, 1'b0, active level of vsync_o
- OUT_LAT, 1, output latency in pix_en_i-qualified cycles; legal range 1..4
- clk_i  in  1  system clock
- arstn_i  in  1  reset; one clock, reset asynchronous and active-low
- pix_en_i  in  1  pixel-clock enable; all timing state advances only when high
- hd_i, hf_i, hr_i, hb_i  in  H_W each  horizontal display, front porch, sync, back porch lengths
- vd_i, vf_i, vr_i, vb_i  in  V_W each  vertical lengths, in lines
- cfg_we_i  in  1  single-cycle configuration write strobe
- cfg_pending_o  out  1  a staged configuration awaits a frame boundary
- cfg_err_o  out  1  one-cycle pulse: the write was rejected
- hsync_o, vsync_o  out  1  sync outputs, polarity per HS_POL/VS_POL
- de_o  out  1  pixel in active area
- hcount_o  out  H_W  active x, 0..hd-1; 0 when de_o low
- vcount_o  out  V_W  active y, 0..vd-1; holds 0 during vertical blanking
- sol_o, sof_o  out  1  first active pixel of a line / of a frame

## Operation
- **Line order:** active, front porch, sync, back porch, then repeat. The horizontal FSM states are H_ACT, H_FP, H_SYNC and H_BP. The vertical FSM states are V_ACT, V_FP, V_SYNC and V_BP.
- **Horizontal segment counter:** loads the segment length minus 1 on entry, decrements on each pix_en_i, and switches state at 0.
- **Vertical advance:** the vertical FSM advances one line on the last pixel of H_BP. Its segment counter behaves the same way, in lines.
- **No total arithmetic:** totals are never computed, so any length in 1..2^W-1 is legal and nothing can overflow.
- **Zero-length fields:** a write with any field equal to 0 is rejected. cfg_err_o pulses, and the active and staged configurations are unchanged.
- **Idle state:** after reset the block is idle. Syncs sit at their inactive level; de, sol, sof and the counts are 0. The first accepted write loads the active registers directly and starts the timing.
- **Write while running:** the values go to the staging registers and cfg_pending_o rises. On the last pixel of the frame (end of V_BP and H_BP) the staged values become active and cfg_pending_o falls. The next frame uses the new timing.
- **Repeated writes before the boundary:** a second write overwrites the staged values.
- **Write on the boundary cycle itself:** that write's values are applied directly, taking priority over the staged values, and cfg_pending_o ends low.
- **Reset mid-frame:** clears all state, including both configurations, and returns the block to idle.

## Timing
- **Start of timing:** an accepted write at edge k (pix_en_i high throughout) places the FSMs at H_ACT/V_ACT with x=0, y=0 after edge k+1.
- **Output alignment:** all outputs are registered. They show the FSM state OUT_LAT pix_en_i-cycles later, so de_o, sof_o and sol_o are first high after edge k+1+OUT_LAT.
- **Delay-line advance:** the delay-line stages advance only on pix_en_i. With pix_en_i low, every output holds.
- **Strobe width:** sof_o and sol_o are high for exactly one pixel. sof_o implies sol_o.
- **Reset values:** hsync_o = ~HS_POL, vsync_o = ~VS_POL; every other output is 0.
- **Config status timing:** cfg_pending_o and cfg_err_o are not delayed by OUT_LAT. Each is valid on the edge after the write.

## Structure
- vga_pkg additions:
  - h_state_e and v_state_e enums.
  - vga_timing_t struct holding the eight length fields, parametrised through VGA_MAX_H_WIDTH/VGA_MAX_V_WIDTH.
  - VGA_MAX_OUT_LAT = 4.
- Sub-module vga_seg_fsm: a generic four-segment state machine with a down-counter. It is instantiated once for the horizontal axis and once for the vertical axis, with an advance input (pix_en_i, or end-of-line) and an end-of-period output.
- The output delay line is a generate loop inside vga_timing_gen.

## Test plan
- **Basic line and frame:** hd=4, hf=1, hr=2, hb=1 and vd=3, vf=1, vr=1, vb=1, pix_en_i=1, OUT_LAT=1.
  - de_o runs 4 high, 4 low per 8-pixel line; hsync_o is active for pixels 5-6.
  - The frame is 48 cycles; vsync_o is active for line 4.
  - sof_o pulses every 48 cycles.
- **Pixel enable at 1/2 rate:** same configuration with pix_en_i toggling every cycle. Every output period doubles, and outputs hold on disabled cycles.
- **Mid-frame reconfiguration:** a write at pixel 10 with hd=6 gives cfg_pending_o=1 until the 48th pixel. The current frame is unchanged, and the next frame's lines are 10 pixels long.
- **Boundary and repeated writes:**
  - A write on the last-pixel cycle, alongside a staged write, applies the new values at once and cfg_pending_o=0.
  - Two writes before the boundary: only the second takes effect.
- **Rejected write:** a write with hr=0 gives a cfg_err_o pulse and no change in timing or cfg_pending_o.
- **Latency, polarity and reset:** with OUT_LAT=3 and HS_POL=1, de_o first rises 4 cycles after the write and hsync_o is active-high. Asserting arstn_i low mid-line drives every output to its reset value immediately; after release the block stays idle until the next write.
